vid_pattern_gen: RTL and testbench

Video stream source. It generates the pixel/sync stream (dout, dv_out, hs_out, vs_out) that the line-buffered filters consume, with a programmable frame size, fixed blanking, and selectable test patterns. It sits at the head of the filter chain, both for bring-up and for block-level benches, and drives filter inputs d_in/dv_in/hs_in/vs_in directly.

---
 rtl/vid_pkg.sv | 18 +
 rtl/vid_pattern_pix.sv | 31 +++
 rtl/vid_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video pattern generator slice.
package vid_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_MIX   = 2'd3;

endpackage

// File: rtl/vid_pattern_pix.sv
// Combinational pixel formatter: maps raster position and frame count to a
// test-pattern pixel value, truncated to WIDTH bits.
module vid_pattern_pix
  import vid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [7:0]       frame_cnt,
  input  logic [1:0]       pattern,
  output logic [WIDTH-1:0] pix
);

  logic [CNT_W-1:0] mix;

  assign mix = x + y + CNT_W'(frame_cnt);

  always_comb begin
    pix = '0;
    case (pattern)
      PAT_HRAMP: pix = WIDTH'(x);
      PAT_VRAMP: pix = WIDTH'(y);
      // 8x8 checkerboard
      PAT_CHECK: pix = (x[3] ^ y[3]) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      PAT_MIX:   pix = WIDTH'(mix);
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Video stream source with programmable frame size and fixed blanking.
// Define VID_GEN_SPARSE_EN to emit one pixel every other active cycle.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [15:0]      pix_count,
  input  logic [15:0]      line_count,
  input  logic [1:0]       pattern,
  output logic [WIDTH-1:0] dout,
  output logic             dv_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic [7:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VBLANK - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] x_reg, x_next;
  logic [CNT_W-1:0] y_reg, y_next;
  logic [CNT_W-1:0] blank_reg, blank_next;
  logic [CNT_W-1:0] pix_sh_reg, pix_sh_next;
  logic [CNT_W-1:0] line_sh_reg, line_sh_next;
  logic [1:0]       pat_sh_reg, pat_sh_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  logic [WIDTH-1:0] dout_reg;
  logic             dv_reg, hs_reg, vs_reg;

  logic             pix_valid;
  logic             line_end;
  logic             x_step;
  logic [WIDTH-1:0] pix_value;

`ifdef VID_GEN_SPARSE_EN
  logic phase_reg, phase_next;

  // Phase 0 carries a pixel, phase 1 is the gap; every line starts on phase 0.
  always_comb begin
    phase_next = (state_reg == ST_ACTIVE) ? ~phase_reg : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_reg <= 1'b0;
    else     phase_reg <= phase_next;
  end

  assign pix_valid = (state_reg == ST_ACTIVE) && !phase_reg;
  assign line_end  = phase_reg && (x_reg == pix_sh_reg - CNT_W'(1));
  assign x_step    = phase_reg;
`else
  assign pix_valid = (state_reg == ST_ACTIVE);
  assign line_end  = (x_reg == pix_sh_reg - CNT_W'(1));
  assign x_step    = 1'b1;
`endif

  vid_pattern_pix #(.WIDTH(WIDTH)) u_pix (
    .x         (x_reg),
    .y         (y_reg),
    .frame_cnt (frame_cnt_reg),
    .pattern   (pat_sh_reg),
    .pix       (pix_value)
  );

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    blank_next     = blank_reg;
    pix_sh_next    = pix_sh_reg;
    line_sh_next   = line_sh_reg;
    pat_sh_next    = pat_sh_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        // Frame geometry and pattern are frozen here for the whole frame.
        if (enable && (pix_count != '0) && (line_count != '0)) begin
          state_next   = ST_ACTIVE;
          pix_sh_next  = pix_count;
          line_sh_next = line_count;
          pat_sh_next  = pattern;
          x_next       = '0;
          y_next       = '0;
        end
      end
      ST_ACTIVE: begin
        if (line_end) begin
          state_next = ST_HBLANK;
          blank_next = '0;
        end else if (x_step) begin
          x_next = x_reg + CNT_W'(1);
        end
      end
      ST_HBLANK: begin
        if (blank_reg == HB_LAST) begin
          if (y_reg == line_sh_reg - CNT_W'(1)) begin
            state_next = ST_VBLANK;
            blank_next = '0;
          end else begin
            state_next = ST_ACTIVE;
            y_next     = y_reg + CNT_W'(1);
            x_next     = '0;
          end
        end else begin
          blank_next = blank_reg + CNT_W'(1);
        end
      end
      ST_VBLANK: begin
        if (blank_reg == VB_LAST) begin
          state_next     = ST_IDLE;
          frame_cnt_next = frame_cnt_reg + 8'd1;
        end else begin
          blank_next = blank_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      blank_reg     <= '0;
      pix_sh_reg    <= '0;
      line_sh_reg   <= '0;
      pat_sh_reg    <= '0;
      frame_cnt_reg <= '0;
      dout_reg      <= '0;
      dv_reg        <= 1'b0;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      blank_reg     <= blank_next;
      pix_sh_reg    <= pix_sh_next;
      line_sh_reg   <= line_sh_next;
      pat_sh_reg    <= pat_sh_next;
      frame_cnt_reg <= frame_cnt_next;
      dv_reg        <= pix_valid;
      hs_reg        <= (state_reg == ST_ACTIVE);
      vs_reg        <= (state_reg == ST_ACTIVE) || (state_reg == ST_HBLANK);
      // dout keeps the last pixel through gaps and blanking.
      if (pix_valid) dout_reg <= pix_value;
    end
  end

  assign dout      = dout_reg;
  assign dv_out    = dv_reg;
  assign hs_out    = hs_reg;
  assign vs_out    = vs_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen with a pixel scoreboard fed from a pattern model.
module tb_vid_pattern_gen;
  import vid_pkg::*;

  localparam int WIDTH = 8;
  localparam int HB    = 2;
  localparam int VB    = 3;
`ifdef VID_GEN_SPARSE_EN
  localparam int SP = 2;
`else
  localparam int SP = 1;
`endif

  logic             clk;
  logic             rst;
  logic             enable;
  logic [15:0]      pix_count;
  logic [15:0]      line_count;
  logic [1:0]       pattern;
  logic [WIDTH-1:0] dout;
  logic             dv_out;
  logic             hs_out;
  logic             vs_out;
  logic [7:0]       frame_cnt;

  vid_pattern_gen #(.WIDTH(WIDTH), .HBLANK(HB), .VBLANK(VB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pix_count  (pix_count),
    .line_count (line_count),
    .pattern    (pattern),
    .dout       (dout),
    .dv_out     (dv_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;
  logic [7:0] exp_fc;
  int         cyc = 0;
  int         hs_cnt, vs_cnt, dv_cnt, hs_pulses, hs_low_run, hs_gap;
  int         vs_rise[$];
  logic       hs_prev = 1'b0;
  logic       vs_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input int x, input int y, input logic [7:0] fc,
                                           input logic [1:0] pat);
    logic [7:0] v;
    case (pat)
      2'd0:    v = 8'(x);
      2'd1:    v = 8'(y);
      2'd2:    v = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      default: v = 8'(x + y + int'(fc));
    endcase
    return v;
  endfunction

  task automatic push_frame(input int pix, input int lines, input logic [1:0] pat,
                            input logic [7:0] fc);
    for (int yy = 0; yy < lines; yy++)
      for (int xx = 0; xx < pix; xx++)
        sb_q.push_back(model_pix(xx, yy, fc, pat));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counters();
    hs_cnt = 0; vs_cnt = 0; dv_cnt = 0; hs_pulses = 0; hs_low_run = 0; hs_gap = -1;
  endtask

  // Output monitor: pops the scoreboard on every valid pixel and tallies envelopes.
  always @(negedge clk) begin
    cyc++;
    if (dv_out === 1'b1) begin
      n_assert++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_pixel: observed dout 0x%0h, expected no pixel", dout);
      end
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check("sb_pixel", 32'(dout), 32'(mon_exp));
      end
      dv_cnt++;
    end
    if (hs_out === 1'b1 && !hs_prev) begin
      hs_pulses++;
      hs_gap = hs_low_run;
    end
    if (hs_out === 1'b1) begin
      hs_cnt++;
      hs_low_run = 0;
    end else begin
      hs_low_run++;
    end
    if (vs_out === 1'b1) vs_cnt++;
    if (vs_out === 1'b1 && !vs_prev) vs_rise.push_back(cyc);
    hs_prev = (hs_out === 1'b1);
    vs_prev = (vs_out === 1'b1);
  end

  task automatic wait_vs_high();
    int n = 0;
    while (vs_out !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    check("vs_wait_timeout", 32'(n >= 4000), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dv"}, dv_out, 0);
    check({tag, "_hs"}, hs_out, 0);
    check({tag, "_vs"}, vs_out, 0);
    check({tag, "_state"}, dut.state_reg, ST_IDLE);
  endtask

  // Runs nf frames; enable drops on line 0 of the last frame (optionally with a pix_count change).
  task automatic do_frames(input int pix, input int lines, input logic [1:0] pat, input int nf,
                           input bit shape, input bit disturb);
    int         n;
    logic [7:0] prev;
    pix_count  = 16'(pix);
    line_count = 16'(lines);
    pattern    = pat;
    clear_counters();
    vs_rise.delete();
    for (int f = 0; f < nf; f++) push_frame(pix, lines, pat, exp_fc + 8'(f));
    enable = 1'b1;
    if (shape) begin
      tick();
      check("start_latency_dv", dv_out, 0);
      for (int i = 0; i < SP * pix; i++) begin
        tick();
        check("line_hs", hs_out, 1);
        check("line_vs", vs_out, 1);
        check("line_dv", dv_out, 32'((i % SP) == 0));
        check("line_dout", 32'(dout), 32'(i / SP));
      end
      tick();
      check("line_end_hs", hs_out, 0);
      check("dout_hold", 32'(dout), 32'(pix - 1));
    end
    for (int f = 0; f < nf; f++) begin
      prev = frame_cnt;
      if (f == nf - 1) begin
        wait_vs_high();
        enable = 1'b0;
        if (disturb) pix_count = 16'(pix + 3);
      end
      n = 0;
      while (frame_cnt === prev && n < 4000) begin
        tick();
        n++;
      end
      check("frame_wait_timeout", 32'(n >= 4000), 0);
      exp_fc++;
      check("frame_cnt", frame_cnt, exp_fc);
      check("hs_cycles", hs_cnt, lines * pix * SP);
      check("dv_cycles", dv_cnt, lines * pix);
      check("vs_cycles", vs_cnt, lines * (SP * pix + HB));
      check("hs_pulses", hs_pulses, lines);
      if (lines > 1) check("hs_gap", hs_gap, HB);
      clear_counters();
    end
    if (shape && nf > 1) check("frame_period", vs_rise[1] - vs_rise[0], lines * (SP * pix + HB) + VB + 1);
    pix_count = 16'(pix);
    repeat (6) tick();
    check_idle("post_frame");
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; pix_count = 16'd4; line_count = 16'd2; pattern = PAT_HRAMP;
    exp_fc = 8'd0;
    repeat (3) tick();
    check("rst_dout", 32'(dout), 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check_idle("rst");
    rst = 1'b0;

    // 4x2 ramp, two back-to-back frames: shape, latency, period
    do_frames(4, 2, PAT_HRAMP, 2, 1'b1, 1'b0);

    // Reset mid-line abandons the frame
    clear_counters();
    push_frame(4, 2, PAT_HRAMP, exp_fc);
    enable = 1'b1;
    n = 0;
    while (dv_out !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_wait_timeout", 32'(n >= 100), 0);
    tick();
    rst = 1'b1; enable = 1'b0;
    tick();
    check("rst_mid_dout", 32'(dout), 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check_idle("rst_mid");
    rst = 1'b0;
    sb_q.delete();
    exp_fc = 8'd0;

    do_frames(4, 2, PAT_MIX, 3, 1'b0, 1'b0);
    do_frames(4, 2, PAT_VRAMP, 1, 1'b0, 1'b1);
    do_frames(16, 16, PAT_CHECK, 1, 1'b0, 1'b0);

    // Zero-sized frames never leave IDLE
    clear_counters();
    pix_count = 16'd0; line_count = 16'd2; enable = 1'b1;
    repeat (10) tick();
    check("zero_pix_state", dut.state_reg, ST_IDLE);
    check("zero_pix_hs", hs_cnt, 0);
    pix_count = 16'd4; line_count = 16'd0;
    repeat (10) tick();
    check("zero_line_state", dut.state_reg, ST_IDLE);
    check("zero_line_hs", hs_cnt, 0);
    enable = 1'b0;
    tick();

    // 256 one-pixel frames walk frame_cnt through 255 -> 0
    do_frames(1, 1, PAT_MIX, 256, 1'b0, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
